// File: rtl/checking_nbits_if.sv
// Button/checker signal bundle for checking_nbits.
// The expected pattern is carried as seq_bits because "sequence" is a reserved word.
interface checking_nbits_if;
  logic       btnR;
  logic       btnL;
  logic       enable;
  logic [2:0] round;
  logic [7:0] seq_bits;
  logic       correct;
  logic       done;
  logic [1:0] led_pressed;
  logic [3:0] index;

  modport master (
    output btnR, btnL, enable, round, seq_bits,
    input  correct, done, led_pressed, index
  );

  modport slave (
    input  btnR, btnL, enable, round, seq_bits,
    output correct, done, led_pressed, index
  );
endinterface

// File: rtl/checking_nbits.sv
// Simon button-entry checker: debounces btnR/btnL and matches presses against a pattern.
// Optional idle timeout is compiled in when CHECK_TIMEOUT_EN is defined.

module checking_nbits_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync_q1;
  logic          sync_q2;
  logic [CW-1:0] cnt;

  // NOTE: reset is synchronous, so it lives inside the clocked branch, not the sensitivity list.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
      cnt     <= '0;
      level   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make sync_q2 take the old sync_q1, forming a real 2-flop chain.
      sync_q1 <= raw;
      sync_q2 <= sync_q1;
      if (sync_q2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= sync_q2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

module checking_nbits #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int TIMEOUT_CYCLES  = 500000000
) (
  input logic             clk,
  input logic             reset,
  checking_nbits_if.slave bus
);
  if (DEBOUNCE_CYCLES < 2 || TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("checking_nbits: DEBOUNCE_CYCLES and TIMEOUT_CYCLES must be >= 2");
  end

  logic       lvl_r, lvl_l;
  logic       prev_r, prev_l;
  logic       evt_r, evt_l;
  logic       correct_q, done_q;
  logic [1:0] led_q;
  logic [3:0] index_q;
  logic       bit_match;
  logic       last_bit;
  logic       timeout_hit;

  checking_nbits_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_r (
    .clk   (clk),
    .reset (reset),
    .raw   (bus.btnR),
    .level (lvl_r)
  );

  checking_nbits_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_l (
    .clk   (clk),
    .reset (reset),
    .raw   (bus.btnL),
    .level (lvl_l)
  );

  // Edge detectors run regardless of enable, so a press held across enable rising stays silent.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_r <= 1'b0;
      prev_l <= 1'b0;
    end else begin
      prev_r <= lvl_r;
      prev_l <= lvl_l;
    end
  end

  assign evt_r     = lvl_r & ~prev_r;
  assign evt_l     = lvl_l & ~prev_l;
  // A right press is bit 1, so the pressed bit equals evt_r for a single press.
  assign bit_match = (evt_r == bus.seq_bits[index_q[2:0]]);
  assign last_bit  = (index_q == {1'b0, bus.round});

`ifdef CHECK_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  logic [TW-1:0] idle_cnt;

  always_ff @(posedge clk) begin
    if (reset || !bus.enable || evt_r || evt_l) begin
      idle_cnt <= '0;
    end else if (!done_q) begin
      idle_cnt <= idle_cnt + 1'b1;
    end
  end

  assign timeout_hit = (idle_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset || !bus.enable) begin
      correct_q <= 1'b0;
      done_q    <= 1'b0;
      led_q     <= 2'b00;
      index_q   <= 4'd0;
    end else if (done_q) begin
      correct_q <= correct_q;
    end else if (evt_r && evt_l) begin
      led_q     <= 2'b11;
      done_q    <= 1'b1;
      correct_q <= 1'b0;
    end else if (evt_r || evt_l) begin
      led_q <= evt_r ? 2'b01 : 2'b10;
      if (bit_match) begin
        index_q <= index_q + 4'd1;
        if (last_bit) begin
          done_q    <= 1'b1;
          correct_q <= 1'b1;
        end
      end else begin
        done_q    <= 1'b1;
        correct_q <= 1'b0;
      end
    end else if (timeout_hit) begin
      done_q    <= 1'b1;
      correct_q <= 1'b0;
    end
  end

  assign bus.correct     = correct_q;
  assign bus.done        = done_q;
  assign bus.led_pressed = led_q;
  assign bus.index       = index_q;
endmodule

// File: tb/tb_checking_nbits.sv
// Scoreboard bench for checking_nbits: stimulus queues expected output states,
// a negedge monitor pops one entry on every change of {correct, done, led_pressed, index}.
module tb_checking_nbits;
  localparam int DEB = 4;
`ifdef CHECK_TIMEOUT_EN
  localparam int TMO = 50;
`else
  localparam int TMO = 1000;
`endif
  localparam logic [7:0] PATTERN = 8'b01100110;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;

  checking_nbits_if bus ();

  checking_nbits #(
    .DEBOUNCE_CYCLES (DEB),
    .TIMEOUT_CYCLES  (TMO)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] outs;
    int         cyc;
    string      name;
  } exp_t;

  exp_t       exp_q[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  bit         mon_en = 1'b0;
  logic [7:0] last_outs;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Output tuple packed as {correct, done, led_pressed[1:0], index[3:0]}.
  task automatic expect_outs(input string name, input logic c, input logic d,
                             input logic [1:0] led, input logic [3:0] idx, input int at_cyc);
    exp_t e;
    e.outs = {c, d, led, idx};
    e.cyc  = at_cyc;
    e.name = name;
    exp_q.push_back(e);
  endtask

  task automatic press(input logic r, input logic l, input int hold);
    bus.btnR = r;
    bus.btnL = l;
    repeat (hold) @(negedge clk);
    bus.btnR = 1'b0;
    bus.btnL = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  task automatic drop_enable(input string name);
    bus.enable = 1'b0;
    expect_outs(name, 1'b0, 1'b0, 2'b00, 4'd0, cyc + 1);
    repeat (2) @(negedge clk);
  endtask

  initial begin : monitor
    logic [7:0] cur;
    exp_t       e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        cur = {bus.correct, bus.done, bus.led_pressed, bus.index};
        if (cur !== last_outs) begin
          if (exp_q.size() == 0) begin
            check("unexpected output change", {24'd0, cur}, {24'd0, last_outs});
          end else begin
            e = exp_q.pop_front();
            check(e.name, {24'd0, cur}, {24'd0, e.outs});
            if (e.cyc >= 0) check({e.name, " edge"}, cyc, e.cyc);
          end
          last_outs = cur;
        end
      end
    end
  end

  initial begin : stimulus
    logic b;
    bus.btnR     = 1'b0;
    bus.btnL     = 1'b0;
    bus.enable   = 1'b0;
    bus.round    = 3'd7;
    bus.seq_bits = PATTERN;
    reset        = 1'b1;
    repeat (3) @(negedge clk);
    check("reset correct", {31'd0, bus.correct}, 32'd0);
    check("reset done", {31'd0, bus.done}, 32'd0);
    check("reset led_pressed", {30'd0, bus.led_pressed}, 32'd0);
    check("reset index", {28'd0, bus.index}, 32'd0);
    reset     = 1'b0;
    last_outs = 8'h00;
    mon_en    = 1'b1;
    @(negedge clk);

    // Full pass: L,R,R,L,L,R,R,L
    bus.enable = 1'b1;
    for (int i = 0; i < 8; i++) begin
      b = PATTERN[i];
      expect_outs($sformatf("pass press %0d", i), i == 7, i == 7,
                  b ? 2'b01 : 2'b10, 4'(i + 1), -1);
      press(b, ~b, 10);
    end

    // Clear for one cycle, then L matches bit 0
    drop_enable("clear after pass");
    bus.enable = 1'b1;
    expect_outs("first L after clear", 1'b0, 1'b0, 2'b10, 4'd1, -1);
    press(1'b0, 1'b1, 10);

    // Early fail: second L mismatches bit 1; a later R is ignored
    expect_outs("early fail", 1'b0, 1'b1, 2'b10, 4'd1, -1);
    press(1'b0, 1'b1, 10);
    press(1'b1, 1'b0, 10);
    drop_enable("clear after fail");

    // Bounce rejection: 2-cycle pulses never survive a 4-cycle debounce
    bus.enable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.btnR = 1'b1;
      repeat (2) @(negedge clk);
      bus.btnR = 1'b0;
      repeat (2) @(negedge clk);
    end
    repeat (12) @(negedge clk);
    bus.enable   = 1'b0;
    bus.round    = 3'd0;
    bus.seq_bits = 8'h01;
    @(negedge clk);
    bus.enable = 1'b1;
    @(negedge clk);
    expect_outs("single-bit pass latency", 1'b1, 1'b1, 2'b01, 4'd1, cyc + DEB + 3);
    press(1'b1, 1'b0, 8);
    drop_enable("clear after single-bit");

    // Simultaneous press is always a failure
    bus.round    = 3'd7;
    bus.seq_bits = PATTERN;
    @(negedge clk);
    bus.enable = 1'b1;
    expect_outs("both buttons", 1'b0, 1'b1, 2'b11, 4'd0, -1);
    press(1'b1, 1'b1, 10);
    drop_enable("clear after both");

`ifdef CHECK_TIMEOUT_EN
    bus.enable = 1'b1;
    expect_outs("idle timeout", 1'b0, 1'b1, 2'b00, 4'd0, cyc + TMO);
    repeat (TMO + 10) @(negedge clk);
    drop_enable("clear after timeout");
`endif

    repeat (10) @(negedge clk);
    check("scoreboard drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
